demux1x3_sequencial: RTL and testbench

Registered 1:3 demultiplexer for the interpolator datapath, the counterpart of the 3:1 sample mux. It accepts a serial stream of 10-bit samples over a valid/ready handshake and distributes consecutive samples into three output slots: slot 0, slot 1, slot 2, in order. When all three slots are filled, it presents them together as one frame. It also drives the slot-select pair `c1`/`c0` using the same encoding the mux consumes, so downstream selection stays aligned with the slot being written.

---
 rtl/interp_pkg.sv | 20 ++
 rtl/demux_slot_reg.sv | 23 ++
 rtl/demux1x3_sequencial.sv | 119 +++++++++++
 tb/tb_demux1x3_sequencial.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/interp_pkg.sv
// Shared definitions for the interpolator sample mux/demux pair.
package interp_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 10;
  localparam int unsigned FRAME_COUNT_W  = 16;

  // Fill/hold sequencing of the 1:3 demux.
  typedef enum logic [1:0] {
    FILL0 = 2'd0,
    FILL1 = 2'd1,
    FILL2 = 2'd2,
    HOLD  = 2'd3
  } demux_state_t;

  // Slot-select encoding {c1,c0}, as consumed by the 3:1 mux.
  localparam logic [1:0] SEL_SLOT0 = 2'b00;
  localparam logic [1:0] SEL_SLOT1 = 2'b10;
  localparam logic [1:0] SEL_SLOT2 = 2'b11;

endpackage

// File: rtl/demux_slot_reg.sv
// One frame slot: sample register with write enable.
module demux_slot_reg
  import interp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  // Capture the sample only when this slot is written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/demux1x3_sequencial.sv
// Registered 1:3 demux: packs three consecutive samples into one frame.
module demux1x3_sequencial
  import interp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    dout_0,
  output logic [DATA_WIDTH-1:0]    dout_1,
  output logic [DATA_WIDTH-1:0]    dout_2,
  output logic                     c1,
  output logic                     c0,
  output logic [FRAME_COUNT_W-1:0] frame_count
);

  demux_state_t state;
  demux_state_t state_nxt;
  logic [2:0]   slot_we;
  logic         frame_take;
  logic         accept;
  logic [1:0]   sel;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL0;
    end else begin
      state <= state_nxt;
    end
  end

  // Ready is held low in reset; in HOLD it follows the consumer so a new frame can start on the drain cycle.
  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      in_ready = (state != HOLD) || out_ready;
    end
  end

  assign accept    = in_valid && in_ready;
  assign out_valid = (state == HOLD);

  // Next state, slot write enables and frame consume; clear overrides everything.
  always_comb begin
    state_nxt  = state;
    slot_we    = 3'b000;
    frame_take = 1'b0;
    if (clear) begin
      state_nxt = FILL0;
    end else begin
      case (state)
        FILL0: if (accept) begin
          slot_we   = 3'b001;
          state_nxt = FILL1;
        end
        FILL1: if (accept) begin
          slot_we   = 3'b010;
          state_nxt = FILL2;
        end
        FILL2: if (accept) begin
          slot_we   = 3'b100;
          state_nxt = HOLD;
        end
        HOLD: if (out_ready) begin
          frame_take = 1'b1;
          if (accept) begin
            slot_we   = 3'b001;
            state_nxt = FILL1;
          end else begin
            state_nxt = FILL0;
          end
        end
        default: state_nxt = FILL0;
      endcase
    end
  end

  // Slot select decoded from the state register only.
  always_comb begin
    sel = SEL_SLOT0;
    case (state)
      FILL1:   sel = SEL_SLOT1;
      FILL2:   sel = SEL_SLOT2;
      default: sel = SEL_SLOT0;
    endcase
  end

  assign c1 = sel[1];
  assign c0 = sel[0];

  // Consumed-frame counter, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_count <= '0;
    end else if (frame_take) begin
      frame_count <= frame_count + FRAME_COUNT_W'(1);
    end
  end

  demux_slot_reg #(.DATA_WIDTH(DATA_WIDTH)) u_slot0 (
    .clk (clk), .rst (rst), .we (slot_we[0]), .d (in_data), .q (dout_0)
  );

  demux_slot_reg #(.DATA_WIDTH(DATA_WIDTH)) u_slot1 (
    .clk (clk), .rst (rst), .we (slot_we[1]), .d (in_data), .q (dout_1)
  );

  demux_slot_reg #(.DATA_WIDTH(DATA_WIDTH)) u_slot2 (
    .clk (clk), .rst (rst), .we (slot_we[2]), .d (in_data), .q (dout_2)
  );

endmodule

// File: tb/tb_demux1x3_sequencial.sv
// Directed bench for the registered 1:3 demux.
module tb_demux1x3_sequencial;

  logic        clk;
  logic        rst;
  logic        clear;
  logic        in_valid;
  logic [9:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  dout_0;
  logic [9:0]  dout_1;
  logic [9:0]  dout_2;
  logic        c1;
  logic        c0;
  logic [15:0] frame_count;

  int n_cmp;
  int n_err;

  demux1x3_sequencial #(.DATA_WIDTH(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .dout_0      (dout_0),
    .dout_1      (dout_1),
    .dout_2      (dout_2),
    .c1          (c1),
    .c0          (c0),
    .frame_count (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one sample for one clock edge; returns at the following falling edge.
  task automatic push(input logic [9:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset.in_ready got %0b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset.out_valid got %0b want 0", out_valid); end
    n_cmp++; if ({dout_0, dout_1, dout_2} !== 30'd0) begin n_err++; $display("FAIL reset.dout got %h/%h/%h want 0", dout_0, dout_1, dout_2); end
    n_cmp++; if ({c1, c0} !== 2'b00) begin n_err++; $display("FAIL reset.sel got %b want 00", {c1, c0}); end
    n_cmp++; if (frame_count !== 16'd0) begin n_err++; $display("FAIL reset.frame_count got %h want 0", frame_count); end
    rst = 1'b0; out_ready = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset.in_ready_release got %0b want 1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_fill_hold();
    test_reset();
    n_cmp++; if ({c1, c0} !== 2'b00) begin n_err++; $display("FAIL fill.sel0 got %b want 00", {c1, c0}); end
    push(10'h011);
    n_cmp++; if ({c1, c0} !== 2'b10) begin n_err++; $display("FAIL fill.sel1 got %b want 10", {c1, c0}); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fill.valid1 got %0b want 0", out_valid); end
    push(10'h022);
    n_cmp++; if ({c1, c0} !== 2'b11) begin n_err++; $display("FAIL fill.sel2 got %b want 11", {c1, c0}); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fill.valid2 got %0b want 0", out_valid); end
    push(10'h033);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL fill.valid3 got %0b want 1", out_valid); end
    n_cmp++; if ({dout_0, dout_1, dout_2} !== {10'h011, 10'h022, 10'h033}) begin n_err++; $display("FAIL fill.frame got %h/%h/%h want 011/022/033", dout_0, dout_1, dout_2); end
    n_cmp++; if ({c1, c0} !== 2'b00) begin n_err++; $display("FAIL fill.sel_hold got %b want 00", {c1, c0}); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fill.in_ready_hold got %0b want 0", in_ready); end
    // Offered sample while held must not disturb the frame.
    push(10'h0EE);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL hold.valid got %0b want 1", out_valid); end
    n_cmp++; if ({dout_0, dout_1, dout_2} !== {10'h011, 10'h022, 10'h033}) begin n_err++; $display("FAIL hold.frame got %h/%h/%h want 011/022/033", dout_0, dout_1, dout_2); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain.valid got %0b want 0", out_valid); end
    n_cmp++; if (frame_count !== 16'd1) begin n_err++; $display("FAIL drain.frame_count got %h want 1", frame_count); end
  endtask

  task automatic test_stream();
    test_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      in_valid = 1'b1;
      in_data  = 10'(i);
      @(negedge clk);
      if (i % 3 == 0) begin
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stream.valid[%0d] got %0b want 1", i, out_valid); end
        n_cmp++; if ({dout_0, dout_1, dout_2} !== {10'(i - 2), 10'(i - 1), 10'(i)}) begin n_err++; $display("FAIL stream.frame[%0d] got %h/%h/%h want %h/%h/%h", i, dout_0, dout_1, dout_2, 10'(i - 2), 10'(i - 1), 10'(i)); end
      end else begin
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream.valid[%0d] got %0b want 0", i, out_valid); end
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream.tail_valid got %0b want 0", out_valid); end
    n_cmp++; if (frame_count !== 16'd3) begin n_err++; $display("FAIL stream.frame_count got %h want 3", frame_count); end
  endtask

  task automatic test_back_to_back();
    test_reset();
    push(10'h100);
    push(10'h200);
    push(10'h300);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 10'h3FF;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b.in_ready got %0b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b.valid got %0b want 0", out_valid); end
    n_cmp++; if ({dout_0, dout_1, dout_2} !== {10'h3FF, 10'h200, 10'h300}) begin n_err++; $display("FAIL b2b.slots got %h/%h/%h want 3ff/200/300", dout_0, dout_1, dout_2); end
    n_cmp++; if ({c1, c0} !== 2'b10) begin n_err++; $display("FAIL b2b.sel got %b want 10", {c1, c0}); end
    n_cmp++; if (frame_count !== 16'd1) begin n_err++; $display("FAIL b2b.frame_count got %h want 1", frame_count); end
  endtask

  task automatic test_clear();
    test_reset();
    push(10'h0AA);
    push(10'h0BB);
    clear = 1'b1;
    push(10'h0CC);
    clear = 1'b0;
    n_cmp++; if ({c1, c0} !== 2'b00) begin n_err++; $display("FAIL clear.sel got %b want 00", {c1, c0}); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL clear.valid got %0b want 0", out_valid); end
    n_cmp++; if ({dout_0, dout_1, dout_2} !== {10'h0AA, 10'h0BB, 10'h000}) begin n_err++; $display("FAIL clear.slots got %h/%h/%h want 0aa/0bb/000", dout_0, dout_1, dout_2); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL clear.valid_next got %0b want 0", out_valid); end
  endtask

  task automatic test_async_reset();
    test_reset();
    push(10'h055);
    push(10'h066);
    n_cmp++; if ({c1, c0} !== 2'b11) begin n_err++; $display("FAIL arst.sel_pre got %b want 11", {c1, c0}); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({c1, c0} !== 2'b00) begin n_err++; $display("FAIL arst.sel got %b want 00", {c1, c0}); end
    n_cmp++; if ({dout_0, dout_1, dout_2} !== 30'd0) begin n_err++; $display("FAIL arst.dout got %h/%h/%h want 0", dout_0, dout_1, dout_2); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL arst.in_ready got %0b want 0", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    push(10'h007);
    push(10'h008);
    push(10'h009);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL arst.valid_after got %0b want 1", out_valid); end
    n_cmp++; if ({dout_0, dout_1, dout_2} !== {10'h007, 10'h008, 10'h009}) begin n_err++; $display("FAIL arst.frame got %h/%h/%h want 007/008/009", dout_0, dout_1, dout_2); end
  endtask

  task automatic test_wrap();
    test_reset();
    // Jump the counter to its top value instead of running 65535 frames.
    force dut.frame_count = 16'hFFFF;
    #1;
    release dut.frame_count;
    push(10'h00A);
    push(10'h00B);
    push(10'h00C);
    n_cmp++; if (frame_count !== 16'hFFFF) begin n_err++; $display("FAIL wrap.count_held got %h want ffff", frame_count); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++; if (frame_count !== 16'h0000) begin n_err++; $display("FAIL wrap.count got %h want 0000", frame_count); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_fill_hold();
    test_stream();
    test_back_to_back();
    test_clear();
    test_async_reset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
